// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller for the Y86-64 pipeline.
// Decodes the memory operation of the current instruction, checks its address
// range, runs a single request/acknowledge handshake with the data RAM
// (bounded by a timeout), and reports completion with a one-cycle done pulse.
module mem_access_ctrl #(
    parameter int unsigned ADDR_MAX = 1023,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [9:0]  bus_addr,
    output logic [63:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          is_read;
    logic          is_write;
    logic [63:0]   sel_addr;
    logic [63:0]   sel_wdata;
    logic          addr_bad;

    logic          op_we;
    logic [9:0]    op_addr;
    logic [63:0]   op_wdata;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Decode the instruction code into direction, address source and write data.
    always_comb begin
        is_read   = 1'b0;
        is_write  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (icode)
            4'h4, 4'hA: begin
                is_write  = 1'b1;
                sel_addr  = valE;
                sel_wdata = valA;
            end
            4'h8: begin
                is_write  = 1'b1;
                sel_addr  = valE;
                sel_wdata = valP;
            end
            4'h5: begin
                is_read  = 1'b1;
                sel_addr = valE;
            end
            4'h9, 4'hB: begin
                is_read  = 1'b1;
                sel_addr = valA;
            end
            default: ;
        endcase
    end

    assign addr_bad = (sel_addr > 64'(ADDR_MAX));
    assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: no-ops and bad addresses skip the bus entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!(is_read || is_write) || addr_bad) begin
                        state_next = DONE;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_ack || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are forced to zero when not requesting.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        bus_req   = (state == REQ);
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (bus_req) begin
            bus_we    = op_we;
            bus_addr  = op_addr;
            bus_wdata = op_wdata;
        end
    end

    // Operation latch, timeout counter, read data and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we      <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            tmo_cnt    <= '0;
            valM       <= '0;
            dmem_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_we      <= is_write;
                        op_addr    <= sel_addr[9:0];
                        op_wdata   <= sel_wdata;
                        tmo_cnt    <= '0;
                        dmem_error <= (is_read || is_write) && addr_bad;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!op_we) begin
                            valM <= bus_rdata;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_hit) begin
                            dmem_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a transaction-level reference model
// is compared against every DUT output on each falling edge, and directed
// scenarios add hand-computed literal expectations.
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_MAX = 1023;
    localparam int unsigned TIMEOUT  = 15;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        busy;
    logic        done;
    logic [63:0] valM;
    logic        dmem_error;
    logic        bus_req;
    logic        bus_we;
    logic [9:0]  bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    mem_access_ctrl #(
        .ADDR_MAX(ADDR_MAX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .icode     (icode),
        .valA      (valA),
        .valE      (valE),
        .valP      (valP),
        .busy      (busy),
        .done      (done),
        .valM      (valM),
        .dmem_error(dmem_error),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // kind: 0 = no memory access, 1 = write, 2 = read
    function automatic void classify(input logic [3:0] ic, input logic [63:0] a,
                                     input logic [63:0] e, input logic [63:0] p,
                                     output int kind, output logic [63:0] addr,
                                     output logic [63:0] data);
        kind = 0;
        addr = 64'd0;
        data = 64'd0;
        if (ic == 4'h4 || ic == 4'hA) begin kind = 1; addr = e; data = a; end
        if (ic == 4'h8)               begin kind = 1; addr = e; data = p; end
        if (ic == 4'h5)               begin kind = 2; addr = e; end
        if (ic == 4'h9 || ic == 4'hB) begin kind = 2; addr = a; end
    endfunction

    bit          m_in_flight;
    bit          m_write;
    logic [63:0] m_addr;
    logic [63:0] m_data;
    int          m_waited;
    bit          e_busy;
    bit          e_done;
    logic [63:0] e_valM;
    bit          e_err;

    // Model advances one transaction step per rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_flight = 0;
            m_write     = 0;
            m_addr      = 0;
            m_data      = 0;
            m_waited    = 0;
            e_busy      = 0;
            e_done      = 0;
            e_valM      = 0;
            e_err       = 0;
        end else begin
            automatic bit finish_now = 0;
            if (m_in_flight) begin
                if (bus_ack) begin
                    if (!m_write) e_valM = bus_rdata;
                    m_in_flight = 0;
                    finish_now  = 1;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin
                        e_err       = 1;
                        m_in_flight = 0;
                        finish_now  = 1;
                    end
                end
            end else if (!e_busy && start) begin
                automatic int kind;
                automatic logic [63:0] a, d;
                classify(icode, valA, valE, valP, kind, a, d);
                e_err = 0;
                if (kind == 0) begin
                    finish_now = 1;
                end else if (a > 64'(ADDR_MAX)) begin
                    e_err      = 1;
                    finish_now = 1;
                end else begin
                    m_in_flight = 1;
                    m_waited    = 0;
                    m_write     = (kind == 1);
                    m_addr      = a;
                    m_data      = d;
                end
            end
            e_done = finish_now;
            e_busy = m_in_flight || finish_now;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy",      busy,       e_busy);
            checkOutput("done",      done,       e_done);
            checkOutput("valM",      valM,       e_valM);
            checkOutput("dmem_error", dmem_error, e_err);
            checkOutput("bus_req",   bus_req,    m_in_flight);
            checkOutput("bus_we",    bus_we,     m_in_flight && m_write);
            checkOutput("bus_addr",  bus_addr,   m_in_flight ? m_addr[9:0] : 10'd0);
            checkOutput("bus_wdata", bus_wdata,  m_in_flight ? m_data : 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] a,
                                 input logic [63:0] e, input logic [63:0] p);
        start = 1'b1;
        icode = ic;
        valA  = a;
        valE  = e;
        valP  = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] a;
        logic [63:0] e;
        logic [63:0] p;
        logic        we;
        logic [9:0]  addr;
        logic [63:0] wd;
        logic [63:0] rd;
    } vec_t;

    vec_t vecs[4];

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] last_m;
        int          req_count;
        int          done_count;
        bit          seen_done;

        vecs[0] = '{4'hA, 64'h1111, 64'd100,  64'd0,     1'b1, 10'd100,  64'h1111, 64'h0};
        vecs[1] = '{4'hB, 64'd200,  64'd7,    64'd0,     1'b0, 10'd200,  64'h0,    64'hCAFE};
        vecs[2] = '{4'h8, 64'h9,    64'd300,  64'h4242,  1'b1, 10'd300,  64'h4242, 64'h0};
        vecs[3] = '{4'h5, 64'd5,    64'd1023, 64'd0,     1'b0, 10'd1023, 64'h0,    64'h55AA};

        rst       = 1'b1;
        start     = 1'b0;
        icode     = 4'h0;
        valA      = 64'd0;
        valE      = 64'd0;
        valP      = 64'd0;
        bus_ack   = 1'b0;
        bus_rdata = 64'd0;
        repeat (2) @(negedge clk);

        checkOutput("reset_busy",    busy,       0);
        checkOutput("reset_done",    done,       0);
        checkOutput("reset_valM",    valM,       0);
        checkOutput("reset_err",     dmem_error, 0);
        checkOutput("reset_bus_req", bus_req,    0);
        rst      = 1'b0;
        check_en = 1;

        // Write path, acknowledged on the third request cycle.
        applyStimulus(4'h4, 64'hDEAD, 64'd16, 64'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wr_req",   bus_req,   1);
            checkOutput("wr_we",    bus_we,    1);
            checkOutput("wr_addr",  bus_addr,  16);
            checkOutput("wr_wdata", bus_wdata, 64'hDEAD);
            checkOutput("wr_done_early", done, 0);
            if (i == 2) bus_ack = 1'b1;
            @(negedge clk);
        end
        bus_ack = 1'b0;
        checkOutput("wr_done", done,       1);
        checkOutput("wr_err",  dmem_error, 0);
        @(negedge clk);
        checkOutput("wr_idle", busy, 0);

        // Read path, acknowledged on the first request cycle.
        applyStimulus(4'h9, 64'd8, 64'd0, 64'd0);
        checkOutput("rd_done_1", done,     0);
        checkOutput("rd_addr",   bus_addr, 8);
        checkOutput("rd_we",     bus_we,   0);
        bus_ack   = 1'b1;
        bus_rdata = 64'h1234;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("rd_done_2", done, 1);
        checkOutput("rd_valM",   valM, 64'h1234);
        @(negedge clk);

        // Address just past the top of memory.
        applyStimulus(4'h5, 64'd0, 64'd1024, 64'd0);
        checkOutput("rng_done", done,       1);
        checkOutput("rng_err",  dmem_error, 1);
        checkOutput("rng_req",  bus_req,    0);
        checkOutput("rng_valM", valM,       64'h1234);
        @(negedge clk);
        checkOutput("rng_err_hold", dmem_error, 1);

        // Remaining opcodes, immediate acknowledge.
        last_m = 64'h1234;
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].ic, vecs[k].a, vecs[k].e, vecs[k].p);
            checkOutput("tbl_req",   bus_req,   1);
            checkOutput("tbl_we",    bus_we,    vecs[k].we);
            checkOutput("tbl_addr",  bus_addr,  vecs[k].addr);
            checkOutput("tbl_wdata", bus_wdata, vecs[k].wd);
            bus_ack   = 1'b1;
            bus_rdata = vecs[k].rd;
            @(negedge clk);
            bus_ack = 1'b0;
            if (!vecs[k].we) last_m = vecs[k].rd;
            checkOutput("tbl_done", done,       1);
            checkOutput("tbl_err",  dmem_error, 0);
            checkOutput("tbl_valM", valM,       last_m);
            @(negedge clk);
        end

        // Timeout on a call with no acknowledge ever.
        applyStimulus(4'h8, 64'd0, 64'd0, 64'hBEEF);
        checkOutput("to_wdata", bus_wdata, 64'hBEEF);
        req_count = 0;
        seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            if (done) begin
                seen_done = 1;
            end else begin
                if (bus_req) req_count++;
                @(negedge clk);
            end
        end
        checkOutput("to_seen_done", seen_done,  1);
        checkOutput("to_req_count", req_count,  15);
        checkOutput("to_err",       dmem_error, 1);
        checkOutput("to_valM",      valM,       64'h55AA);
        @(negedge clk);

        // No-op, with a second start arriving while still busy.
        applyStimulus(4'h6, 64'd1, 64'd2, 64'd3);
        checkOutput("nop_done", done,       1);
        checkOutput("nop_req",  bus_req,    0);
        checkOutput("nop_err",  dmem_error, 0);
        done_count = 1;
        applyStimulus(4'h4, 64'h77, 64'd16, 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (done) done_count++;
            checkOutput("ign_req", bus_req, 0);
            @(negedge clk);
        end
        checkOutput("ign_done_count", done_count, 1);

        // Acknowledge while idle must not disturb anything.
        bus_ack   = 1'b1;
        bus_rdata = 64'hFFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("stray_ack_valM", valM, 64'h55AA);
        checkOutput("stray_ack_done", done, 0);

        // Asynchronous reset in the middle of a request.
        applyStimulus(4'h5, 64'd0, 64'd32, 64'd0);
        checkOutput("ar_req_before", bus_req, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_req_now",  bus_req, 0);
        checkOutput("ar_busy_now", busy,    0);
        checkOutput("ar_valM_now", valM,    0);
        @(negedge clk);
        rst       = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 64'h777;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("ar_late_ack_done", done, 0);
        checkOutput("ar_late_ack_valM", valM, 0);

        // Normal operation after reset.
        applyStimulus(4'hB, 64'd40, 64'd0, 64'd0);
        checkOutput("post_req",  bus_req,  1);
        checkOutput("post_addr", bus_addr, 40);
        bus_ack   = 1'b1;
        bus_rdata = 64'hABC;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("post_done", done, 1);
        checkOutput("post_valM", valM, 64'hABC);
        @(negedge clk);

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
